// File: rtl/ddr_tx_serializer_if.sv
// Parallel-word input stream for ddr_tx_serializer: data/valid from the producer, ready back.
interface ddr_tx_serializer_if #(
    parameter int WORD_W = 8
);
    logic [WORD_W-1:0] in_data;
    logic              in_valid;
    logic              in_ready;

    modport master (output in_data, output in_valid, input in_ready);
    modport slave  (input in_data, input in_valid, output in_ready);
endinterface

// File: rtl/ddr_tx_serializer.sv
// Purpose: buffers parallel words in a small FIFO and emits them LSB pair first to an O_DDR.
// Latency: word pushed at edge k into an idle, empty block shows pair 0 after edge k+1.
// Backpressure: registered in_ready = FIFO not full after the last edge; tx_en low pauses output.
module ddr_tx_serializer #(
    parameter int WORD_W     = 8,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                clk,
    input  logic                rst,
    ddr_tx_serializer_if.slave  in_if,
    input  logic                tx_en,
    output logic [1:0]          ddr_d,
    output logic                ddr_en,
    output logic                busy,
    output logic [15:0]         tx_count
);
    localparam int AW    = $clog2(FIFO_DEPTH);
    localparam int PAIRS = WORD_W / 2;
    localparam int PC_W  = $clog2(PAIRS);
    localparam logic [PC_W-1:0] PC_LAST = PC_W'(PAIRS - 1);

    typedef enum logic {IDLE, SHIFT} state_t;

    state_t              state_q, state_n;
    logic [WORD_W-1:0]   mem [FIFO_DEPTH];
    logic [AW:0]         wr_ptr_q, rd_ptr_q, wr_ptr_n, rd_ptr_n;
    logic                in_ready_q;
    logic                push, pop, fifo_empty, full_n;
    logic [WORD_W-1:0]   head;
    logic [WORD_W-1:0]   sr_q, sr_n;
    logic [PC_W-1:0]     pc_q, pc_n;
    logic [1:0]          ddr_d_q, ddr_d_n;
    logic                ddr_en_q, ddr_en_n;
    logic [15:0]         tx_count_q, tx_count_n;

    // in_ready is a registered view of fullness, so a same-edge pop never opens a slot for a push
    assign push       = in_if.in_valid && in_ready_q;
    assign fifo_empty = (wr_ptr_q == rd_ptr_q);
    assign head       = mem[rd_ptr_q[AW-1:0]];
    assign wr_ptr_n   = wr_ptr_q + {{AW{1'b0}}, push};
    assign rd_ptr_n   = rd_ptr_q + {{AW{1'b0}}, pop};
    assign full_n     = (wr_ptr_n[AW] != rd_ptr_n[AW]) &&
                        (wr_ptr_n[AW-1:0] == rd_ptr_n[AW-1:0]);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            in_ready_q <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_n;
            rd_ptr_q   <= rd_ptr_n;
            in_ready_q <= !full_n;
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr_q[AW-1:0]] <= in_if.in_data;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= IDLE;
            sr_q       <= '0;
            pc_q       <= '0;
            ddr_d_q    <= 2'b00;
            ddr_en_q   <= 1'b0;
            tx_count_q <= '0;
        end else begin
            state_q    <= state_n;
            sr_q       <= sr_n;
            pc_q       <= pc_n;
            ddr_d_q    <= ddr_d_n;
            ddr_en_q   <= ddr_en_n;
            tx_count_q <= tx_count_n;
        end
    end

    always_comb begin
        state_n    = state_q;
        sr_n       = sr_q;
        pc_n       = pc_q;
        ddr_d_n    = ddr_d_q;
        ddr_en_n   = 1'b0;
        tx_count_n = tx_count_q;
        pop        = 1'b0;
        case (state_q)
            IDLE: begin
                ddr_d_n = 2'b00;
                if (!fifo_empty && tx_en) begin
                    pop      = 1'b1;
                    sr_n     = head;
                    ddr_d_n  = head[1:0];
                    ddr_en_n = 1'b1;
                    pc_n     = '0;
                    state_n  = SHIFT;
                end
            end
            SHIFT: begin
                if (tx_en) begin
                    if (pc_q != PC_LAST) begin
                        sr_n     = sr_q >> 2;
                        ddr_d_n  = sr_q[3:2];
                        ddr_en_n = 1'b1;
                        pc_n     = pc_q + PC_W'(1);
                    end else begin
                        tx_count_n = tx_count_q + 16'd1;
                        // Chain straight into the next word so ddr_en has no bubble
                        if (!fifo_empty) begin
                            pop      = 1'b1;
                            sr_n     = head;
                            ddr_d_n  = head[1:0];
                            ddr_en_n = 1'b1;
                            pc_n     = '0;
                        end else begin
                            state_n  = IDLE;
                            ddr_d_n  = 2'b00;
                        end
                    end
                end
            end
            default: state_n = IDLE;
        endcase
    end

    assign in_if.in_ready = in_ready_q;
    assign ddr_d          = ddr_d_q;
    assign ddr_en         = ddr_en_q;
    assign busy           = !fifo_empty || (state_q == SHIFT);
    assign tx_count       = tx_count_q;
endmodule
